// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Takes one 32-bit word per handshake, presented as four bytes B1..B4
// (B1 = word[31:24] ... B4 = word[7:0]), stores it in a 2-entry word buffer
// and emits it as four bytes, one per accepted output cycle.
//
// Parameters
//   MSB_FIRST   1: emit B1,B2,B3,B4   0: emit B4,B3,B2,B1
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears all state
//   in_valid    producer has a word on B1..B4
//   in_ready    buffer has room (occupancy < 2); registered-state decode only
//   B1..B4      word bytes, most significant first
//   out_valid   out_byte holds a valid byte (occupancy > 0)
//   out_ready   consumer accepts out_byte this cycle
//   out_byte    current byte (0 while nothing is buffered)
//   out_last    current byte is the fourth byte of its word
//   checksum    sum mod 256 of every transferred byte since reset
//   word_count  number of fully transferred words since reset, wraps
// -----------------------------------------------------------------------------
module byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  B1,
  input  logic [7:0]  B2,
  input  logic [7:0]  B3,
  input  logic [7:0]  B4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [7:0]  checksum,
  output logic [15:0] word_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] mem [2];
  logic        head, head_next;
  logic [1:0]  occ, occ_next;
  logic [1:0]  idx, idx_next;

  logic        push;
  logic        xfer;
  logic        word_done;
  logic        tail;
  logic [31:0] head_word;
  logic [1:0]  sel;

  // Handshake decodes. in_ready looks only at registered occupancy, so there
  // is no combinational path from out_ready to in_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign word_done = xfer && (idx == 2'd3);

  // Tail slot: same as head when empty, the other slot when one word is held.
  // A simultaneous last-byte pop and push at occupancy 1 therefore writes the
  // slot that becomes the new head.
  assign tail = head ^ occ[0];

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    head_next  = head;
    occ_next   = occ;
    idx_next   = idx;
    unique case (state)
      IDLE: begin
        idx_next = 2'd0;
        if (push) begin
          occ_next   = 2'd1;
          state_next = SEND;
        end
      end
      SEND: begin
        // idx is 2 bits wide, so 3 + 1 returns to 0 on the word's last byte.
        if (xfer) idx_next = idx + 2'd1;
        if (word_done) head_next = ~head;
        occ_next   = occ + {1'b0, push} - {1'b0, word_done};
        state_next = (occ_next == 2'd0) ? IDLE : SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      head       <= 1'b0;
      occ        <= 2'd0;
      idx        <= 2'd0;
      checksum   <= 8'h00;
      word_count <= 16'h0000;
    end else begin
      state <= state_next;
      head  <= head_next;
      occ   <= occ_next;
      idx   <= idx_next;
      if (xfer)      checksum   <= checksum + out_byte;
      if (word_done) word_count <= word_count + 16'd1;
    end
  end

  // NOTE: the word buffer has no reset; its contents are only observed while
  // occupancy marks them valid, and out_byte is forced to 0 otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {B1, B2, B3, B4};
  end

  // Byte select: sel 0 is the most significant byte; LSB-first order simply
  // walks the select in reverse.
  assign head_word = mem[head];
  assign sel       = MSB_FIRST ? idx : ~idx;

  always_comb begin
    out_byte = 8'h00;
    if (out_valid) begin
      unique case (sel)
        2'd0: out_byte = head_word[31:24];
        2'd1: out_byte = head_word[23:16];
        2'd2: out_byte = head_word[15:8];
        2'd3: out_byte = head_word[7:0];
        default: out_byte = 8'h00;
      endcase
    end
  end

  assign out_last = out_valid && (idx == 2'd3);

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_byte_serializer
//
// Drives an MSB-first and an LSB-first byte_serializer with identical stimulus
// and compares both against a queue-based model of the word buffer: the model
// holds the buffered words and the byte position inside the head word, and
// derives every output from those.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  B1, B2, B3, B4;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_out_last;
  logic [7:0]  m_out_byte, m_checksum;
  logic [15:0] m_word_count;
  logic        l_in_ready, l_out_valid, l_out_last;
  logic [7:0]  l_out_byte, l_checksum;
  logic [15:0] l_word_count;

  always #5 clk = ~clk;

  byte_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_byte(m_out_byte),
    .out_last(m_out_last), .checksum(m_checksum), .word_count(m_word_count)
  );

  byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_byte(l_out_byte),
    .out_last(l_out_last), .checksum(l_checksum), .word_count(l_word_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];     // buffered words, head first
  int          pos;       // bytes already sent from the head word
  logic [7:0]  cks_m, cks_l;
  logic [15:0] wc;
  bit          pushed;

  logic [31:0] prod[$];   // words the producer still has to deliver

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k, input bit msb);
    logic [31:0] t;
    t = msb ? (w >> ((3 - k) * 8)) : (w >> (k * 8));
    return t[7:0];
  endfunction

  task automatic model_clear();
    mq.delete();
    pos   = 0;
    cks_m = 8'h00;
    cks_l = 8'h00;
    wc    = 16'h0000;
  endtask

  // One rising edge of the buffer, using the inputs held across that edge.
  task automatic model_edge();
    bit rdy, vld, xfer;
    rdy    = (mq.size() < 2);
    vld    = (mq.size() > 0);
    pushed = in_valid && rdy;
    xfer   = vld && out_ready;
    if (xfer) begin
      cks_m = cks_m + byte_of(mq[0], pos, 1'b1);
      cks_l = cks_l + byte_of(mq[0], pos, 1'b0);
      pos++;
      if (pos == 4) begin
        pos = 0;
        void'(mq.pop_front());
        wc = wc + 16'd1;
      end
    end
    if (pushed) mq.push_back({B1, B2, B3, B4});
  endtask

  task automatic compare_all();
    bit vld;
    vld = (mq.size() > 0);
    check("msb_in_ready",   m_in_ready,   (mq.size() < 2));
    check("lsb_in_ready",   l_in_ready,   (mq.size() < 2));
    check("msb_out_valid",  m_out_valid,  vld);
    check("lsb_out_valid",  l_out_valid,  vld);
    check("msb_out_byte",   m_out_byte,   vld ? byte_of(mq[0], pos, 1'b1) : 8'h00);
    check("lsb_out_byte",   l_out_byte,   vld ? byte_of(mq[0], pos, 1'b0) : 8'h00);
    check("msb_out_last",   m_out_last,   vld && (pos == 3));
    check("lsb_out_last",   l_out_last,   vld && (pos == 3));
    check("msb_checksum",   m_checksum,   cks_m);
    check("lsb_checksum",   l_checksum,   cks_l);
    check("msb_word_count", m_word_count, wc);
    check("lsb_word_count", l_word_count, wc);
  endtask

  // One clock cycle: set inputs, let the edge happen, compare on the falling edge.
  task automatic cyc(input bit gate, input bit ordy);
    in_valid = gate && (prod.size() > 0);
    if (in_valid) {B1, B2, B3, B4} = prod[0];
    else          {B1, B2, B3, B4} = $urandom;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (pushed) void'(prod.pop_front());
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    model_clear();
    prod.delete();
    compare_all();
    check("rst_in_ready",   m_in_ready,   1);
    check("rst_out_valid",  m_out_valid,  0);
    check("rst_out_byte",   m_out_byte,   0);
    check("rst_out_last",   m_out_last,   0);
    check("rst_checksum",   m_checksum,   0);
    check("rst_word_count", m_word_count, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] log_b[$];
  logic [7:0] exp3 [12];
  logic [7:0] exp4 [4];

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {B1, B2, B3, B4} = 32'h0;
    model_clear();
    repeat (2) @(negedge clk);

    // --- single word, both byte orders ---
    do_reset();
    prod.push_back(32'h12345678);
    cyc(1, 1);
    check("w1_b0_msb", m_out_byte, 8'h12);
    check("w1_b0_lsb", l_out_byte, 8'h78);
    cyc(1, 1);
    check("w1_b1_msb", m_out_byte, 8'h34);
    cyc(1, 1);
    check("w1_b2_msb", m_out_byte, 8'h56);
    check("w1_b2_last", m_out_last, 1'b0);
    cyc(1, 1);
    check("w1_b3_msb", m_out_byte, 8'h78);
    check("w1_b3_last", m_out_last, 1'b1);
    check("w1_b3_lsb", l_out_byte, 8'h12);
    cyc(1, 1);
    check("w1_checksum", m_checksum, 8'h14);
    check("w1_word_count", m_word_count, 16'd1);
    check("w1_idle", m_out_valid, 1'b0);

    do_reset();
    prod.push_back(32'hAABBCCDD);
    cyc(1, 1);
    check("w2_b0_lsb", l_out_byte, 8'hDD);
    cyc(1, 1);
    check("w2_b1_lsb", l_out_byte, 8'hCC);
    cyc(1, 1);
    check("w2_b2_lsb", l_out_byte, 8'hBB);
    cyc(1, 1);
    check("w2_b3_lsb", l_out_byte, 8'hAA);
    check("w2_b3_last", l_out_last, 1'b1);
    cyc(1, 1);

    // --- back-pressure: fill the buffer, hold the third word, then drain ---
    do_reset();
    prod.push_back(32'hA1A2A3A4);
    prod.push_back(32'hB1B2B3B4);
    prod.push_back(32'hC1C2C3C4);
    cyc(1, 0);
    check("bp_ready_after1", m_in_ready, 1'b1);
    cyc(1, 0);
    check("bp_ready_after2", m_in_ready, 1'b0);
    cyc(1, 0);
    check("bp_third_held", m_in_ready, 1'b0);
    exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
             8'hC1, 8'hC2, 8'hC3, 8'hC4};
    log_b.delete();
    for (int i = 0; i < 12; i++) begin
      check("bp_no_gap", m_out_valid, 1'b1);
      log_b.push_back(m_out_byte);
      cyc(1, 1);
      if (i == 2) check("bp_ready_before4", m_in_ready, 1'b0);
      if (i == 3) check("bp_ready_after4",  m_in_ready, 1'b1);
    end
    for (int i = 0; i < 12; i++) check("bp_seq", log_b[i], exp3[i]);
    check("bp_word_count", m_word_count, 16'd3);

    // --- consumer toggling out_ready ---
    do_reset();
    prod.push_back(32'hDEADBEEF);
    cyc(1, 0);
    exp4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    log_b.delete();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) log_b.push_back(m_out_byte);
      cyc(0, (i % 2 == 1));
    end
    for (int i = 0; i < 4; i++) check("tog_seq", log_b[i], exp4[i]);
    check("tog_checksum", m_checksum, 8'h38);
    check("tog_word_count", m_word_count, 16'd1);

    // --- reset in the middle of a word ---
    do_reset();
    prod.push_back(32'h01020304);
    cyc(1, 1);
    cyc(1, 1);
    cyc(1, 1);
    check("mid_b2_msb", m_out_byte, 8'h03);
    do_reset();
    prod.push_back(32'h05060708);
    cyc(1, 1);
    check("mid_next_byte", m_out_byte, 8'h05);
    repeat (4) cyc(1, 1);
    check("mid_word_count", m_word_count, 16'd1);
    check("mid_checksum", m_checksum, 8'h1A);

    // --- randomized traffic, with one reset dropped in the middle ---
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      while (prod.size() < 2) prod.push_back($urandom);
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    // --- long stream of 0x00000001: checksum wraps past 255 ---
    do_reset();
    for (int i = 0; i < 300; i++) prod.push_back(32'h00000001);
    for (int i = 0; i < 1210; i++) cyc(1, 1);
    check("stream_word_count", m_word_count, 16'd300);
    check("stream_checksum", m_checksum, 8'h2C);
    check("stream_idle", m_out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
